bram_access_ctrl: RTL and testbench

Load/store front end for the byte-enabled block RAM used as core data memory. Accepts one core request at a time over a valid/ready handshake and converts byte/half/word accesses into word-addressed reads and byte-enabled writes. Aligns and sign/zero-extends read data and returns every request's completion on a valid/ready response channel. Sits between the core's memory stage and the byte-enabled BRAM, driving that BRAM's read and write ports directly.

---
 rtl/bram_access_ctrl_if.sv | 42 ++++
 rtl/bram_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_bram_access_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_access_ctrl_if.sv
// Request/response and BRAM-port bundle for bram_access_ctrl.
// slave = controller view, master = core + RAM environment view.
interface bram_access_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH+1:0] req_address;
    logic [31:0]           req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;

    logic                  mem_readEnable;
    logic [ADDR_WIDTH-1:0] mem_readAddress;
    logic [31:0]           mem_readData;
    logic                  mem_writeEnable;
    logic [3:0]            mem_writeByteEnable;
    logic [ADDR_WIDTH-1:0] mem_writeAddress;
    logic [31:0]           mem_writeData;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        input  rsp_ready, mem_readData,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_readEnable, mem_readAddress, mem_writeEnable,
        output mem_writeByteEnable, mem_writeAddress, mem_writeData
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        output rsp_ready, mem_readData,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_readEnable, mem_readAddress, mem_writeEnable,
        input  mem_writeByteEnable, mem_writeAddress, mem_writeData
    );
endinterface

// File: rtl/bram_access_ctrl.sv
// Byte/half/word load-store front end for a byte-enabled BRAM, one request in flight.
// Optional misalignment trap: define BRAM_ACCESS_MISALIGN_CHECK_EN.
module bram_access_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    bram_access_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        RESP
    } state_t;

    state_t      r_state;
    logic        r_rspValid;
    logic [31:0] r_rspRdata;
    logic        r_rspError;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;

    logic        w_reqReady;
    logic        w_accept;
    logic        w_misalign;
    logic        w_readEnable;
    logic        w_writeEnable;
    logic [3:0]  w_byteEnable;
    logic [31:0] w_writeData;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadData;

    // Ready is held low for the whole time reset is asserted.
    assign w_reqReady = (r_state == IDLE) && !reset;
    assign w_accept   = bus.req_valid && w_reqReady;

`ifdef BRAM_ACCESS_MISALIGN_CHECK_EN
    always_comb begin
        case (bus.req_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = bus.req_address[0];
            2'b10:   w_misalign = (bus.req_address[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_readEnable  = w_accept && !bus.req_write && !w_misalign;
    assign w_writeEnable = w_accept &&  bus.req_write && !w_misalign;

    always_comb begin
        w_byteEnable = 4'b1111;
        w_writeData  = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                w_byteEnable = 4'b0001 << bus.req_address[1:0];
                w_writeData  = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_byteEnable = bus.req_address[1] ? 4'b1100 : 4'b0011;
                w_writeData  = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_byteEnable = 4'b1111;
                w_writeData  = bus.req_wdata;
            end
        endcase
    end

    assign bus.req_ready           = w_reqReady;
    assign bus.mem_readEnable      = w_readEnable;
    assign bus.mem_writeEnable     = w_writeEnable;
    assign bus.mem_writeByteEnable = w_writeEnable ? w_byteEnable : 4'b0000;
    assign bus.mem_readAddress     = bus.req_address[ADDR_WIDTH+1:2];
    assign bus.mem_writeAddress    = bus.req_address[ADDR_WIDTH+1:2];
    assign bus.mem_writeData       = w_writeData;

    // Lane select and extension use the offset/size captured at accept time.
    always_comb begin
        w_byte     = bus.mem_readData[{r_offset, 3'b000} +: 8];
        w_half     = r_offset[1] ? bus.mem_readData[31:16] : bus.mem_readData[15:0];
        w_loadData = bus.mem_readData;
        case (r_size)
            2'b00:   w_loadData = {{24{!r_unsigned && w_byte[7]}}, w_byte};
            2'b01:   w_loadData = {{16{!r_unsigned && w_half[15]}}, w_half};
            default: w_loadData = bus.mem_readData;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rspValid <= 1'b0;
            r_rspRdata <= 32'h0;
            r_rspError <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_offset   <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (bus.req_write || w_misalign) begin
                            r_rspRdata <= 32'h0;
                            r_rspError <= w_misalign;
                            r_rspValid <= 1'b1;
                            r_state    <= RESP;
                        end else begin
                            r_size     <= bus.req_size;
                            r_unsigned <= bus.req_unsigned;
                            r_offset   <= bus.req_address[1:0];
                            r_state    <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    r_rspRdata <= w_loadData;
                    r_rspError <= 1'b0;
                    r_rspValid <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_rspValid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_rdata = r_rspRdata;
    assign bus.rsp_error = r_rspError;

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Randomized + directed self-checking bench for bram_access_ctrl against a byte-array memory model.
module tb_bram_access_ctrl;

    localparam int AW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cycleCount = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cycleCount <= cycleCount + 1;

    bram_access_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    bram_access_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Attached block RAM: synchronous byte-enabled write, registered read.
    logic [31:0] ram [256];
    always @(posedge clock) begin
        if (bus.mem_writeEnable)
            for (int i = 0; i < 4; i++)
                if (bus.mem_writeByteEnable[i])
                    ram[bus.mem_writeAddress][8*i +: 8] <= bus.mem_writeData[8*i +: 8];
        if (bus.mem_readEnable)
            bus.mem_readData <= ram[bus.mem_readAddress];
    end

    // Reference model: flat byte-addressed memory.
    logic [7:0] refMem [1024];

    function automatic logic isMisaligned(input logic [1:0] sz, input logic [9:0] addr);
`ifdef BRAM_ACCESS_MISALIGN_CHECK_EN
        return (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) || (sz == 2'd3);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int numBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int baseOf(input logic [1:0] sz, input logic [9:0] addr);
        int n = numBytes(sz);
        return (int'(addr) / n) * n;
    endfunction

    function automatic void refStore(input logic [1:0] sz, input logic [9:0] addr, input logic [31:0] wd);
        int n = numBytes(sz);
        int b = baseOf(sz, addr);
        if (isMisaligned(sz, addr)) return;
        for (int i = 0; i < n; i++) refMem[b + i] = wd[8*i +: 8];
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic uns, input logic [9:0] addr);
        int n = numBytes(sz);
        int b = baseOf(sz, addr);
        longint v = 0;
        if (isMisaligned(sz, addr)) return 32'h0;
        for (int i = 0; i < n; i++) v = v + (longint'(refMem[b + i]) << (8 * i));
        if (!uns && n < 4 && refMem[b + n - 1][7]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [31:0] lat;
        logic        rdEn;
        logic        wrEn;
        logic [3:0]  be;
        logic [7:0]  rAddr;
        logic [7:0]  wAddr;
        logic [31:0] wData;
        logic [31:0] acc;
    } obs_t;

    task automatic doTxn(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wd, output obs_t o);
        int n;
        o = '0;
        @(negedge clock);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_address  = addr;
        bus.req_wdata    = wd;
        bus.rsp_ready    = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        o.rdEn  = bus.mem_readEnable;
        o.wrEn  = bus.mem_writeEnable;
        o.be    = bus.mem_writeByteEnable;
        o.rAddr = bus.mem_readAddress;
        o.wAddr = bus.mem_writeAddress;
        o.wData = bus.mem_writeData;
        o.acc   = cycleCount;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.rsp_valid && n < 20);
        o.lat = n;
        o.rd  = bus.rsp_rdata;
        o.err = bus.rsp_error;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        vectors++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.mem_readEnable, bus.mem_writeEnable} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.mem_readEnable, bus.mem_writeEnable});
        end
        vectors++;
        if (bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h expected 00000000", bus.rsp_rdata);
        end
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0",
                     bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_word();
        obs_t o;
        doTxn(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, o);
        refStore(2'd2, 10'h010, 32'hDEADBEEF);
        vectors++;
        if (o.wrEn !== 1'b1 || o.be !== 4'b1111 || o.wAddr !== 8'h04) begin
            miscompares++;
            $display("[TB] FAIL word_store_strobes: got we=%b be=%b wa=%h expected we=1 be=1111 wa=04", o.wrEn, o.be, o.wAddr);
        end
        vectors++;
        if (o.lat !== 32'd1 || o.rd !== 32'h0 || o.err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL word_store_rsp: got lat=%0d rd=%h err=%b expected lat=1 rd=0 err=0", o.lat, o.rd, o.err);
        end
        doTxn(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, o);
        vectors++;
        if (o.rdEn !== 1'b1 || o.rAddr !== 8'h04 || o.lat !== 32'd2 || o.rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL word_load: got re=%b ra=%h lat=%0d rd=%h expected re=1 ra=04 lat=2 rd=deadbeef",
                     o.rdEn, o.rAddr, o.lat, o.rd);
        end
    endtask

    task automatic test_byte();
        obs_t o;
        doTxn(1'b1, 2'd0, 1'b0, 10'h013, 32'h00000080, o);
        refStore(2'd0, 10'h013, 32'h00000080);
        vectors++;
        if (o.be !== 4'b1000 || o.wData !== 32'h80808080) begin
            miscompares++;
            $display("[TB] FAIL byte_store: got be=%b wd=%h expected be=1000 wd=80808080", o.be, o.wData);
        end
        doTxn(1'b0, 2'd0, 1'b0, 10'h013, 32'h0, o);
        vectors++;
        if (o.rd !== 32'hFFFFFF80) begin
            miscompares++;
            $display("[TB] FAIL byte_load_signed: got %h expected ffffff80", o.rd);
        end
        doTxn(1'b0, 2'd0, 1'b1, 10'h013, 32'h0, o);
        vectors++;
        if (o.rd !== 32'h00000080) begin
            miscompares++;
            $display("[TB] FAIL byte_load_unsigned: got %h expected 00000080", o.rd);
        end
    endtask

    task automatic test_half();
        obs_t o;
        logic [31:0] expWord;
        doTxn(1'b1, 2'd1, 1'b0, 10'h022, 32'h00001234, o);
        refStore(2'd1, 10'h022, 32'h00001234);
        vectors++;
        if (o.be !== 4'b1100 || o.wData !== 32'h12341234) begin
            miscompares++;
            $display("[TB] FAIL half_store: got be=%b wd=%h expected be=1100 wd=12341234", o.be, o.wData);
        end
        doTxn(1'b0, 2'd1, 1'b1, 10'h022, 32'h0, o);
        vectors++;
        if (o.rd !== 32'h00001234) begin
            miscompares++;
            $display("[TB] FAIL half_load: got %h expected 00001234", o.rd);
        end
        expWord = refLoad(2'd2, 1'b0, 10'h020);
        doTxn(1'b0, 2'd2, 1'b0, 10'h020, 32'h0, o);
        vectors++;
        if (o.rd !== expWord || o.rd[31:16] !== 16'h1234) begin
            miscompares++;
            $display("[TB] FAIL half_word_view: got %h expected %h", o.rd, expWord);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        logic [31:0] expRd;
        int n;
        expRd = refLoad(2'd2, 1'b0, 10'h010);
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_address = 10'h010; bus.rsp_ready = 1'b0;
        @(posedge clock);
        #1;
        bus.req_write = 1'b1; bus.req_address = 10'h030; bus.req_wdata = 32'hA5A55A5A;
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.rsp_valid && n < 20);
        held = bus.rsp_rdata;
        vectors++;
        if (n !== 2 || held !== expRd) begin
            miscompares++;
            $display("[TB] FAIL stall_first: got lat=%0d rd=%h expected lat=2 rd=%h", n, held, expRd);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            vectors++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0 ||
                bus.mem_readEnable !== 1'b0 || bus.mem_writeEnable !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall_hold: got v=%b rd=%h rdy=%b re=%b we=%b expected v=1 rd=%h rdy=0 re=0 we=0",
                         bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.mem_readEnable, bus.mem_writeEnable, held);
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        vectors++;
        if (bus.mem_writeEnable !== 1'b0 || bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL retire_no_accept: got we=%b rdy=%b expected we=0 rdy=0", bus.mem_writeEnable, bus.req_ready);
        end
        @(negedge clock);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.mem_writeEnable !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL accept_after_retire: got rdy=%b we=%b v=%b expected rdy=1 we=1 v=0",
                     bus.req_ready, bus.mem_writeEnable, bus.rsp_valid);
        end
        refStore(2'd2, 10'h030, 32'hA5A55A5A);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL stall_store_rsp: got v=%b rd=%h expected v=1 rd=0", bus.rsp_valid, bus.rsp_rdata);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_misalign();
        obs_t o;
        logic expMis;
        logic [31:0] expRd;
        expMis = isMisaligned(2'd2, 10'h021);
        expRd  = refLoad(2'd2, 1'b0, 10'h021);
        doTxn(1'b0, 2'd2, 1'b0, 10'h021, 32'h0, o);
        vectors++;
        if (o.err !== expMis || o.rd !== expRd || o.rdEn !== !expMis || o.lat !== (expMis ? 32'd1 : 32'd2)) begin
            miscompares++;
            $display("[TB] FAIL misalign_word: got err=%b rd=%h re=%b lat=%0d expected err=%b rd=%h re=%b",
                     o.err, o.rd, o.rdEn, o.lat, expMis, expRd, !expMis);
        end
        if (!expMis) begin
            vectors++;
            if (o.rAddr !== 8'h08) begin
                miscompares++;
                $display("[TB] FAIL misalign_addr: got %h expected 08", o.rAddr);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t s, l1, l2;
        logic [31:0] d;
        d = $urandom;
        doTxn(1'b1, 2'd2, 1'b0, 10'h040, d, s);
        refStore(2'd2, 10'h040, d);
        doTxn(1'b0, 2'd2, 1'b0, 10'h040, 32'h0, l1);
        doTxn(1'b0, 2'd0, 1'b1, 10'h041, 32'h0, l2);
        vectors++;
        if (l1.rd !== d || l1.acc - s.acc !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL b2b_store_load: got rd=%h gap=%0d expected rd=%h gap=2", l1.rd, l1.acc - s.acc, d);
        end
        vectors++;
        if (l2.acc - l1.acc !== 32'd3 || l2.rd !== {24'h0, d[15:8]}) begin
            miscompares++;
            $display("[TB] FAIL b2b_load_load: got gap=%0d rd=%h expected gap=3 rd=%h", l2.acc - l1.acc, l2.rd, {24'h0, d[15:8]});
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
        bus.req_address = 10'h010; bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.mem_readEnable !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_reset: got v=%b rdy=%b re=%b expected 0 0 0", bus.rsp_valid, bus.req_ready, bus.mem_readEnable);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_readEnable !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_release: got rdy=%b v=%b re=%b expected 1 0 0", bus.req_ready, bus.rsp_valid, bus.mem_readEnable);
        end
        repeat (3) @(negedge clock);
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midop_discard: got v=%b expected 0", bus.rsp_valid);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic w, uns, mis;
        logic [1:0] sz;
        logic [9:0] addr;
        logic [31:0] wd, expRd;
        logic [3:0] expBe;
        int b, n;
        for (int t = 0; t < 150; t++) begin
            w    = $urandom_range(0, 1);
            sz   = $urandom_range(0, 3);
            uns  = $urandom_range(0, 1);
            addr = $urandom_range(0, 63);
            wd   = $urandom;
            mis  = isMisaligned(sz, addr);
            n    = numBytes(sz);
            b    = baseOf(sz, addr);
            expRd = w ? 32'h0 : refLoad(sz, uns, addr);
            expBe = (w && !mis) ? 4'(((1 << n) - 1) << (b % 4)) : 4'b0000;
            doTxn(w, sz, uns, addr, wd, o);
            if (w) refStore(sz, addr, wd);
            vectors++;
            if (o.rd !== expRd || o.err !== mis || o.lat !== ((w || mis) ? 32'd1 : 32'd2)) begin
                miscompares++;
                $display("[TB] FAIL rand_rsp t=%0d: got rd=%h err=%b lat=%0d expected rd=%h err=%b (w=%b sz=%0d a=%h)",
                         t, o.rd, o.err, o.lat, expRd, mis, w, sz, addr);
            end
            vectors++;
            if (o.rdEn !== (!w && !mis) || o.wrEn !== (w && !mis) || o.be !== expBe) begin
                miscompares++;
                $display("[TB] FAIL rand_strobe t=%0d: got re=%b we=%b be=%b expected re=%b we=%b be=%b",
                         t, o.rdEn, o.wrEn, o.be, !w && !mis, w && !mis, expBe);
            end
            if (!mis) begin
                vectors++;
                if ((w ? o.wAddr : o.rAddr) !== addr[9:2]) begin
                    miscompares++;
                    $display("[TB] FAIL rand_addr t=%0d: got %h expected %h", t, w ? o.wAddr : o.rAddr, addr[9:2]);
                end
            end
            if (w && !mis) begin
                for (int l = 0; l < 4; l++) begin
                    if (expBe[l]) begin
                        vectors++;
                        if (o.wData[8*l +: 8] !== wd[8*(l - b % 4) +: 8]) begin
                            miscompares++;
                            $display("[TB] FAIL rand_lane t=%0d lane=%0d: got %h expected %h",
                                     t, l, o.wData[8*l +: 8], wd[8*(l - b % 4) +: 8]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        for (int i = 0; i < 1024; i++) refMem[i] = 8'h0;
        bus.mem_readData = 32'h0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_address = '0; bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_stall();
        test_misalign();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
